// File: rtl/ns_arb_pkg.sv
// ns_arb_pkg: shared mode enum and index helpers for the request arbiters
package ns_arb_pkg;
  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  function automatic int idx_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
  function automatic int nxt(input int i, input int w);
    return i == 0 ? w - 1 : i - 1;
  endfunction
endpackage

// File: rtl/ns_prio_enc.sv
// ns_prio_enc: combinational MSB-first priority encoder for any width
module ns_prio_enc import ns_arb_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    idx = '0;
    valid = |req;
    for (int i = 0; i < WIDTH; i++) if (req[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/ns_rr_prio_arb.sv
// ns_rr_prio_arb: fixed or round-robin arbiter with a registered valid/ready grant
module ns_rr_prio_arb import ns_arb_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [WIDTH-1:0] gnt_onehot
);
  localparam bit RR = (MODE == int'(ARB_RR));
  logic             hs, load, m_any, r_any;
  logic [IDX_W-1:0] ptr, ptr_nxt, ptr_eff, m_idx, r_idx, sel;
  logic [WIDTH-1:0] mask, masked;
  assign hs      = out_valid & out_ready;
  assign load    = ~out_valid | out_ready;
  assign ptr_nxt = IDX_W'(nxt(int'(gnt_idx), WIDTH));
  // the pointer advance from this edge's handshake already steers this edge's pick
  assign ptr_eff = hs ? ptr_nxt : ptr;
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) mask[i] = (i <= int'(ptr_eff));
  end
  assign masked = req & mask;
  ns_prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_m (.req(masked), .idx(m_idx), .valid(m_any));
  ns_prio_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc_r (.req(req), .idx(r_idx), .valid(r_any));
  assign sel = (RR && m_any) ? m_idx : r_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= IDX_W'(WIDTH - 1);
    end else begin
      if (load) begin
        out_valid  <= r_any;
        gnt_idx    <= r_any ? sel : '0;
        gnt_onehot <= r_any ? WIDTH'(1) << sel : '0;
      end
      if (RR && hs) ptr <= ptr_nxt;
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    gnt_onehot == (out_valid ? WIDTH'(1) << gnt_idx : '0));
  a_ptr: assert property (@(posedge clk) disable iff (rst) int'(ptr) < WIDTH);
  a_idle: assert property (@(posedge clk) disable iff (rst) !out_valid |-> gnt_idx == '0);
endmodule
